blue_ctrl: RTL and testbench

BLUE_CTRL -- requirements
Module: blue_ctrl

---
 rtl/blue_pkg.sv | 46 ++++
 rtl/blue_cmd_fifo.sv | 51 +++++
 rtl/blue_ctrl.sv | 149 ++++++++++++++
 tb/tb_blue_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blue_pkg.sv
// blue_pkg: shared definitions for the blue_ctrl command sequencer.
// Holds the FSM state enum, the command word field positions, the cond
// encodings, the flag bit positions and a helper that evaluates a cond.
// Optional feature macro used by blue_ctrl: BLUE_CTRL_COND_EN.
package blue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } state_e;

  // Command word layout (LSB position of each field).
  localparam int unsigned OpcodeLsb = 16;
  localparam int unsigned RaLsb     = 13;
  localparam int unsigned RbLsb     = 10;
  localparam int unsigned WaLsb     = 7;
  localparam int unsigned WbLsb     = 4;
  localparam int unsigned WeABit    = 3;
  localparam int unsigned WeBBit    = 2;
  localparam int unsigned CondLsb   = 0;

  localparam logic [1:0] CondAlways = 2'b00;
  localparam logic [1:0] CondZ      = 2'b01;
  localparam logic [1:0] CondN      = 2'b10;
  localparam logic [1:0] CondC      = 2'b11;

  // Flags vector is {Z, N, C}.
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 0;

  function automatic logic cond_pass(logic [1:0] cond, logic [2:0] flags);
    logic pass;
    unique case (cond)
      CondAlways: pass = 1'b1;
      CondZ:      pass = flags[FlagZ];
      CondN:      pass = flags[FlagN];
      CondC:      pass = flags[FlagC];
      default:    pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/blue_cmd_fifo.sv
// blue_cmd_fifo: synchronous command queue, power-of-2 depth.
// Ports: clk, rst (async active-high), push/wdata write side, pop/rdata
// read side (rdata shows the head, first-word fall-through), full, empty.
// Push while full and pop while empty are ignored.
module blue_cmd_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = FIFO_DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/blue_ctrl.sv
// blue_ctrl: command sequencer with an 8x16 register file driving an
// external datapath. Commands are queued in blue_cmd_fifo, issued with
// operands read from the register file, and written back DP_LAT+1 cycles
// later from the datapath results.
// Ports: clk, rst (async active-high); cmd_valid/cmd_ready/cmd_data push;
// ld_en/ld_addr/ld_data/ld_ready host load; rd_addr/rd_data host read;
// dp_opcode/dp_a/dp_b to datapath; dp_a_res/dp_b_res/dp_znc from datapath;
// flags {Z,N,C}, busy, done (one pulse per retired command).
// Optional macro BLUE_CTRL_COND_EN: cmd cond field gates execution.
module blue_ctrl
  import blue_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DP_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [15:0] dp_opcode,
  output logic [15:0] dp_a,
  output logic [15:0] dp_b,
  input  logic [15:0] dp_a_res,
  input  logic [15:0] dp_b_res,
  input  logic [2:0]  dp_znc,
  output logic [2:0]  flags,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LatM1 = 3'(DP_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] regs_q [8];
  logic [2:0]  flags_q;
  logic [15:0] dp_opcode_q, dp_a_q, dp_b_q;
  logic [2:0]  wa_q, wb_q;
  logic        we_a_q, we_b_q, skip_q;

  logic [31:0] head;
  logic        fifo_full, fifo_empty, pop, exec;

  blue_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (32)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .wdata(cmd_data),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef BLUE_CTRL_COND_EN
  assign exec = cond_pass(head[CondLsb +: 2], flags_q);
`else
  logic unused_cond;
  assign unused_cond = ^head[CondLsb +: 2];
  assign exec        = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StIssue;
      end
      StIssue: begin
        pop = 1'b1;
        // A command that fails its cond skips the datapath wait entirely.
        cnt_d   = exec ? LatM1 : 3'd0;
        state_d = exec ? StWait : StWb;
      end
      StWait: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = StWb;
      end
      StWb: begin
        done    = 1'b1;
        state_d = fifo_empty ? StIdle : StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      flags_q     <= '0;
      dp_opcode_q <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      wa_q        <= '0;
      wb_q        <= '0;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      skip_q      <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIssue) begin
        skip_q <= ~exec;
        wa_q   <= head[WaLsb +: 3];
        wb_q   <= head[WbLsb +: 3];
        we_a_q <= head[WeABit];
        we_b_q <= head[WeBBit];
        if (exec) begin
          dp_opcode_q <= head[OpcodeLsb +: 16];
          dp_a_q      <= regs_q[head[RaLsb +: 3]];
          dp_b_q      <= regs_q[head[RbLsb +: 3]];
        end
      end
      // Loads are blocked during WB, so they never collide with writeback.
      if (ld_en && ld_ready) regs_q[ld_addr] <= ld_data;
      if (state_q == StWb && !skip_q) begin
        // B is written first so A wins when both target the same register.
        if (we_b_q) regs_q[wb_q] <= dp_b_res;
        if (we_a_q) regs_q[wa_q] <= dp_a_res;
        flags_q <= dp_znc;
      end
    end
  end

  assign cmd_ready = ~fifo_full;
  assign ld_ready  = (state_q != StWb);
  assign rd_data   = regs_q[rd_addr];
  assign dp_opcode = dp_opcode_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign flags     = flags_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_blue_ctrl.sv
// tb_blue_ctrl: directed self-checking bench for blue_ctrl (defaults
// FIFO_DEPTH=4, DP_LAT=1) with a behavioural adder datapath.
module tb_blue_ctrl;

  localparam int unsigned DpLat = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [15:0] dp_opcode, dp_a, dp_b, dp_a_res, dp_b_res;
  logic [2:0]  dp_znc, flags;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Datapath model: A_res = A+B, B_res = A, {Z,N,C} from the sum.
  logic [16:0] sum;
  assign sum      = {1'b0, dp_a} + {1'b0, dp_b};
  assign dp_a_res = sum[15:0];
  assign dp_b_res = dp_a;
  assign dp_znc   = {(sum[15:0] == 16'h0), sum[15], sum[16]};

  blue_ctrl #(
    .FIFO_DEPTH(4),
    .DP_LAT    (DpLat)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dp_opcode(dp_opcode),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_a_res (dp_a_res),
    .dp_b_res (dp_b_res),
    .dp_znc   (dp_znc),
    .flags    (flags),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [31:0] make_cmd(logic [15:0] op, logic [2:0] ra, logic [2:0] rb,
                                           logic [2:0] wa, logic [2:0] wb, logic we_a,
                                           logic we_b, logic [1:0] cond);
    return {op, ra, rb, wa, wb, we_a, we_b, cond};
  endfunction

  task automatic load_reg(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] c);
    cmd_valid = 1'b1; cmd_data = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_reg(input logic [2:0] a, output logic [15:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  // Returns number of negedges until done is seen (40 means timed out).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b exp 1", ld_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flags); end
    checks++; if ({dp_opcode, dp_a, dp_b} !== 48'h0) begin
      errors++; $display("FAIL reset_dp got %h %h %h exp 0", dp_opcode, dp_a, dp_b);
    end
    for (int i = 0; i < 8; i++) begin
      get_reg(3'(i), v);
      checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0000", i, v); end
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    logic [15:0] v;
    load_reg(3'd1, 16'd3);
    load_reg(3'd2, 16'd4);
    push_one(make_cmd(16'hA001, 3'd1, 3'd2, 3'd3, 3'd0, 1'b1, 1'b0, 2'b00));
    wait_done(cyc);
    checks++; if (cyc !== int'(DpLat + 2)) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, DpLat + 2); end
    checks++; if (dp_opcode !== 16'hA001) begin errors++; $display("FAIL basic_opcode got %h exp a001", dp_opcode); end
    checks++; if (dp_a !== 16'd3) begin errors++; $display("FAIL basic_dp_a got %h exp 0003", dp_a); end
    checks++; if (dp_b !== 16'd4) begin errors++; $display("FAIL basic_dp_b got %h exp 0004", dp_b); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    get_reg(3'd3, v);
    checks++; if (v !== 16'd7) begin errors++; $display("FAIL basic_r3 got %h exp 0007", v); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL basic_flags got %b exp 000", flags); end
  endtask

  task automatic test_flags();
    int cyc;
    logic [15:0] v;
    load_reg(3'd1, 16'hFFFF);
    load_reg(3'd2, 16'h0001);
    load_reg(3'd4, 16'h1234);
    push_one(make_cmd(16'hA002, 3'd1, 3'd2, 3'd4, 3'd0, 1'b1, 1'b0, 2'b00));
    wait_done(cyc);
    checks++; if (cyc >= 40) begin errors++; $display("FAIL flags_timeout got %0d exp <40", cyc); end
    @(negedge clk);
    get_reg(3'd4, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL flags_r4 got %h exp 0000", v); end
    checks++; if (flags !== 3'b101) begin errors++; $display("FAIL flags_znc got %b exp 101", flags); end
  endtask

  task automatic test_load_in_issue();
    int cyc;
    logic [15:0] v;
    load_reg(3'd1, 16'd5);
    load_reg(3'd2, 16'd6);
    push_one(make_cmd(16'hA003, 3'd1, 3'd2, 3'd3, 3'd0, 1'b1, 1'b0, 2'b00));
    @(negedge clk);              // FSM is in ISSUE for the coming edge
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'd100;
    @(negedge clk);
    ld_en = 1'b0;
    wait_done(cyc);
    checks++; if (dp_a !== 16'd5) begin errors++; $display("FAIL issue_load_dp_a got %h exp 0005", dp_a); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL wb_ld_ready got %b exp 0", ld_ready); end
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'h0055;  // must be ignored
    @(negedge clk);
    ld_en = 1'b0;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL post_wb_ld_ready got %b exp 1", ld_ready); end
    get_reg(3'd3, v);
    checks++; if (v !== 16'd11) begin errors++; $display("FAIL issue_load_r3 got %h exp 000b", v); end
    get_reg(3'd1, v);
    checks++; if (v !== 16'd100) begin errors++; $display("FAIL issue_load_r1 got %h exp 0064", v); end
    get_reg(3'd2, v);
    checks++; if (v !== 16'd6) begin errors++; $display("FAIL wb_load_ignored_r2 got %h exp 0006", v); end
  endtask

  task automatic test_same_dest();
    int cyc;
    logic [15:0] v;
    load_reg(3'd1, 16'd10);
    load_reg(3'd2, 16'd20);
    push_one(make_cmd(16'hA004, 3'd1, 3'd2, 3'd5, 3'd5, 1'b1, 1'b1, 2'b00));
    wait_done(cyc);
    @(negedge clk);
    get_reg(3'd5, v);
    checks++; if (v !== 16'd30) begin errors++; $display("FAIL same_dest_r5 got %h exp 001e", v); end
    push_one(make_cmd(16'hA005, 3'd1, 3'd2, 3'd6, 3'd7, 1'b1, 1'b1, 2'b00));
    wait_done(cyc);
    @(negedge clk);
    get_reg(3'd6, v);
    checks++; if (v !== 16'd30) begin errors++; $display("FAIL dual_r6 got %h exp 001e", v); end
    get_reg(3'd7, v);
    checks++; if (v !== 16'd10) begin errors++; $display("FAIL dual_r7 got %h exp 000a", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c [6];
    logic [15:0] got [6];
    int ndone = 0;
    int pushed = 0;
    bit saw_low = 1'b0;
    for (int k = 0; k < 6; k++) c[k] = make_cmd(16'h0100 + 16'(k), 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
    fork
      begin
        int guard = 0;
        logic acc;
        cmd_valid = 1'b1; cmd_data = c[0];
        while (pushed < 6 && guard < 50) begin
          acc = cmd_ready;       // ready only changes at posedge
          if (!cmd_ready) saw_low = 1'b1;
          @(negedge clk);
          guard++;
          if (acc) begin
            pushed++;
            if (pushed < 6) cmd_data = c[pushed];
          end
        end
        cmd_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(negedge clk);
          if (done) begin
            if (ndone < 6) got[ndone] = dp_opcode;
            ndone++;
          end
        end
      end
    join
    checks++; if (pushed !== 6) begin errors++; $display("FAIL b2b_pushed got %0d exp 6", pushed); end
    checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL b2b_ready_low got %b exp 1", saw_low); end
    checks++; if (ndone !== 6) begin errors++; $display("FAIL b2b_done_count got %0d exp 6", ndone); end
    for (int k = 0; k < 6; k++) begin
      if (k < ndone) begin
        checks++; if (got[k] !== 16'h0100 + 16'(k)) begin
          errors++; $display("FAIL b2b_order%0d got %h exp %h", k, got[k], 16'h0100 + 16'(k));
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    bit saw_done = 1'b0;
    bit saw_busy = 1'b0;
    load_reg(3'd1, 16'd1);
    load_reg(3'd2, 16'd2);
    cmd_valid = 1'b1;
    cmd_data = make_cmd(16'hB000, 3'd1, 3'd2, 3'd6, 3'd0, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    cmd_data = make_cmd(16'hB001, 3'd1, 3'd2, 3'd6, 3'd0, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    cmd_data = make_cmd(16'hB002, 3'd1, 3'd2, 3'd6, 3'd0, 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    cmd_valid = 1'b0;            // first command in WAIT, two queued
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got %b exp 1", cmd_ready); end
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b exp 0", saw_done); end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle got %b exp 0", saw_busy); end
    get_reg(3'd6, v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL rstmid_r6 got %h exp 0000", v); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b exp 000", flags); end
  endtask

  task automatic test_cond();
    int cyc;
    logic [15:0] v;
    load_reg(3'd1, 16'd2);
    load_reg(3'd2, 16'd3);
    load_reg(3'd3, 16'h0077);
    push_one(make_cmd(16'hC001, 3'd1, 3'd2, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01));
    wait_done(cyc);
`ifdef BLUE_CTRL_COND_EN
    checks++; if (cyc !== 2) begin errors++; $display("FAIL cond_skip_latency got %0d exp 2", cyc); end
    @(negedge clk);
    get_reg(3'd3, v);
    checks++; if (v !== 16'h0077) begin errors++; $display("FAIL cond_skip_r3 got %h exp 0077", v); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL cond_skip_flags got %b exp 000", flags); end
    push_one(make_cmd(16'hC002, 3'd1, 3'd2, 3'd3, 3'd0, 1'b1, 1'b0, 2'b00));
    wait_done(cyc);
`endif
    checks++; if (cyc !== int'(DpLat + 2)) begin errors++; $display("FAIL cond_exec_latency got %0d exp %0d", cyc, DpLat + 2); end
    @(negedge clk);
    get_reg(3'd3, v);
    checks++; if (v !== 16'd5) begin errors++; $display("FAIL cond_exec_r3 got %h exp 0005", v); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL cond_exec_flags got %b exp 000", flags); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_load_in_issue();
    test_same_dest();
    test_back_to_back();
    test_reset_mid();
    test_cond();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
